// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel clock-enable, syncs, DE and strobes
// Optional one-pixel lookahead outputs (fetch_*) are enabled by VGA_TIMING_PREFETCH_EN.
module vga_timing_gen #(
   parameter int   CNT_W    = 11,
   parameter int   CLK_DIV  = 2,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic             clk_50,
   input  logic             rst_n,
   input  logic             en,
   output logic             pix_ce,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             de,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_PREFETCH_EN
   ,
   output logic             fetch_de,
   output logic [CNT_W-1:0] fetch_x,
   output logic [CNT_W-1:0] fetch_y
`endif
);

   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
   logic             pix_ce_q, pix_ce_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic [CNT_W-1:0] px_q, px_d, py_q, py_d;
   logic             ls_q, ls_d, fs_q, fs_d;

   logic             tick, h_wrap, h_nxt_wrap;
   logic [CNT_W-1:0] h_nxt, v_nxt, h_nn, v_nn;
   logic             nxt_de;

`ifdef VGA_TIMING_PREFETCH_EN
   logic             fde_q, fde_d;
   logic [CNT_W-1:0] fx_q, fx_d, fy_q, fy_d;
   logic             nn_de;
`endif

   always_comb begin
      tick       = (div_q == DIV_LAST);
      h_wrap     = (h_q == H_LAST);
      h_nxt      = h_wrap ? '0 : h_q + 1'b1;
      v_nxt      = h_wrap ? ((v_q == V_LAST) ? '0 : v_q + 1'b1) : v_q;
      nxt_de     = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      // Position after next, used only for the lookahead outputs.
      h_nxt_wrap = (h_nxt == H_LAST);
      h_nn       = h_nxt_wrap ? '0 : h_nxt + 1'b1;
      v_nn       = h_nxt_wrap ? ((v_nxt == V_LAST) ? '0 : v_nxt + 1'b1) : v_nxt;

      div_d    = div_q;
      h_d      = h_q;
      v_d      = v_q;
      pix_ce_d = 1'b0;
      hs_d     = hs_q;
      vs_d     = vs_q;
      de_d     = de_q;
      px_d     = px_q;
      py_d     = py_q;
      ls_d     = 1'b0;
      fs_d     = 1'b0;
`ifdef VGA_TIMING_PREFETCH_EN
      nn_de    = (h_nn < H_ACT) && (v_nn < V_ACT);
      fde_d    = fde_q;
      fx_d     = fx_q;
      fy_d     = fy_q;
`endif

      if (!en) begin
         div_d = '0;
         h_d   = H_LAST;
         v_d   = V_LAST;
         hs_d  = ~HS_POL;
         vs_d  = ~VS_POL;
         de_d  = 1'b0;
         px_d  = '0;
         py_d  = '0;
`ifdef VGA_TIMING_PREFETCH_EN
         fde_d = 1'b1;
         fx_d  = '0;
         fy_d  = '0;
`endif
      end else begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            h_d      = h_nxt;
            v_d      = v_nxt;
            pix_ce_d = 1'b1;
            hs_d     = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? HS_POL : ~HS_POL;
            vs_d     = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? VS_POL : ~VS_POL;
            de_d     = nxt_de;
            px_d     = nxt_de ? h_nxt : '0;
            py_d     = nxt_de ? v_nxt : '0;
            ls_d     = (h_nxt == '0);
            fs_d     = (h_nxt == '0) && (v_nxt == '0);
`ifdef VGA_TIMING_PREFETCH_EN
            fde_d    = nn_de;
            fx_d     = nn_de ? h_nn : '0;
            fy_d     = nn_de ? v_nn : '0;
`endif
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         h_q      <= H_LAST;
         v_q      <= V_LAST;
         pix_ce_q <= 1'b0;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         de_q     <= 1'b0;
         px_q     <= '0;
         py_q     <= '0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         pix_ce_q <= pix_ce_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         de_q     <= de_d;
         px_q     <= px_d;
         py_q     <= py_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
      end
   end

`ifdef VGA_TIMING_PREFETCH_EN
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         fde_q <= 1'b1;
         fx_q  <= '0;
         fy_q  <= '0;
      end else begin
         fde_q <= fde_d;
         fx_q  <= fx_d;
         fy_q  <= fy_d;
      end
   end

   assign fetch_de = fde_q;
   assign fetch_x  = fx_q;
   assign fetch_y  = fy_q;
`endif

   assign pix_ce      = pix_ce_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign de          = de_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default 640x480 timing plus a tiny raster with CLK_DIV=1
module tb_vga_timing_gen;
   localparam int W = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en_d, en_s;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         d_pix_ce, d_hs, d_vs, d_de, d_ls, d_fs;
   logic [W-1:0] d_px, d_py;
   logic         s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs;
   logic [W-1:0] s_px, s_py;
`ifdef VGA_TIMING_PREFETCH_EN
   logic         d_fde, s_fde;
   logic [W-1:0] d_fx, d_fy, s_fx, s_fy;
`endif

   int vectors = 0;
   int miscompares = 0;

   vga_timing_gen dut_d (
      .clk_50(clk), .rst_n(rst_n), .en(en_d),
      .pix_ce(d_pix_ce), .vga_hs(d_hs), .vga_vs(d_vs), .de(d_de),
      .pixel_x(d_px), .pixel_y(d_py), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .fetch_de(d_fde), .fetch_x(d_fx), .fetch_y(d_fy)
`endif
   );

   vga_timing_gen #(
      .CNT_W(W), .CLK_DIV(1),
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_s (
      .clk_50(clk), .rst_n(rst_n), .en(en_s),
      .pix_ce(s_pix_ce), .vga_hs(s_hs), .vga_vs(s_vs), .de(s_de),
      .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_PREFETCH_EN
      , .fetch_de(s_fde), .fetch_x(s_fx), .fetch_y(s_fy)
`endif
   );

   task automatic wait_tick_d(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d_pix_ce && n < 4000);
      if (!d_pix_ce) begin
         vectors++;
         miscompares++;
         $display("FAIL tick_timeout got no pix_ce within %0d clks", n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      en_d  = 1'b1;
      en_s  = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({d_pix_ce, d_hs, d_vs, d_de, d_ls, d_fs, d_px, d_py} !== {6'b011000, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL reset_default got %b_%0d_%0d want 011000_0_0",
                  {d_pix_ce, d_hs, d_vs, d_de, d_ls, d_fs}, d_px, d_py);
      end
      vectors++;
      if ({s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs, s_px, s_py} !== {6'b000000, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL reset_small got %b_%0d_%0d want 000000_0_0",
                  {s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs}, s_px, s_py);
      end
`ifdef VGA_TIMING_PREFETCH_EN
      vectors++;
      if ({d_fde, d_fx, d_fy} !== {1'b1, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL reset_fetch got %b_%0d_%0d want 1_0_0", d_fde, d_fx, d_fy);
      end
`endif
   endtask

   int first_tick_cyc;

   task automatic test_first_tick;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (d_pix_ce !== 1'b0) begin
         miscompares++;
         $display("FAIL first_tick_early pix_ce got %b want 0 at clk 1", d_pix_ce);
      end
      @(negedge clk);
      first_tick_cyc = cyc;
      vectors++;
      if ({d_pix_ce, d_de, d_ls, d_fs, d_hs, d_vs, d_px, d_py} !== {6'b111111, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL first_tick got %b_%0d_%0d want 111111_0_0",
                  {d_pix_ce, d_de, d_ls, d_fs, d_hs, d_vs}, d_px, d_py);
      end
      @(negedge clk);
      vectors++;
      if ({d_pix_ce, d_de, d_ls, d_fs} !== 4'b0100) begin
         miscompares++;
         $display("FAIL first_tick_hold got %b want 0100", {d_pix_ce, d_de, d_ls, d_fs});
      end
   endtask

   task automatic test_line;
      int n, hs_cnt, hs_first, de_cnt, bad_period, pos_err, ls_err, exp_h, exp_v;
      logic exp_de;
      hs_cnt = 0; hs_first = -1; de_cnt = 1; bad_period = 0; pos_err = 0; ls_err = 0;
      for (int k = 1; k <= 800; k++) begin
         wait_tick_d(n);
         if (k > 1 && n != 2) bad_period++;
         exp_h  = k % 800;
         exp_v  = k / 800;
         exp_de = (exp_h < 640) && (exp_v < 480);
         if (d_de !== exp_de || d_px !== (exp_de ? W'(exp_h) : 11'd0) ||
             d_py !== (exp_de ? W'(exp_v) : 11'd0) || d_vs !== 1'b1) pos_err++;
         if (k < 800) begin
            if (d_hs === 1'b0) begin
               hs_cnt++;
               if (hs_first < 0) hs_first = k;
            end
            if (d_de === 1'b1) de_cnt++;
            if (d_ls !== 1'b0) ls_err++;
         end
      end
      vectors++;
      if ({d_ls, d_fs, d_px, d_py} !== {2'b10, 11'd0, 11'd1}) begin
         miscompares++;
         $display("FAIL line_wrap got ls/fs %b x=%0d y=%0d want 10 x=0 y=1", {d_ls, d_fs}, d_px, d_py);
      end
      vectors++;
      if (cyc - first_tick_cyc != 1600) begin
         miscompares++;
         $display("FAIL line_period got %0d clks want 1600", cyc - first_tick_cyc);
      end
      vectors++;
      if (hs_cnt != 96) begin miscompares++; $display("FAIL hs_width got %0d want 96", hs_cnt); end
      vectors++;
      if (hs_first != 656) begin miscompares++; $display("FAIL hs_start got %0d want 656", hs_first); end
      vectors++;
      if (de_cnt != 640) begin miscompares++; $display("FAIL de_width got %0d want 640", de_cnt); end
      vectors++;
      if (bad_period != 0) begin miscompares++; $display("FAIL tick_period got %0d bad want 0", bad_period); end
      vectors++;
      if (pos_err != 0) begin miscompares++; $display("FAIL line_position got %0d errs want 0", pos_err); end
      vectors++;
      if (ls_err != 0) begin miscompares++; $display("FAIL line_start_spurious got %0d want 0", ls_err); end
   endtask

   task automatic test_en_drop;
      int n;
      for (int k = 0; k < 320; k++) wait_tick_d(n);
      vectors++;
      if ({d_de, d_px, d_py} !== {1'b1, 11'd320, 11'd1}) begin
         miscompares++;
         $display("FAIL pre_drop got de=%b x=%0d y=%0d want 1 320 1", d_de, d_px, d_py);
      end
      en_d = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({d_pix_ce, d_hs, d_vs, d_de, d_ls, d_fs, d_px, d_py} !== {6'b011000, 11'd0, 11'd0}) begin
            miscompares++;
            $display("FAIL en_low_%0d got %b_%0d_%0d want 011000_0_0", k,
                     {d_pix_ce, d_hs, d_vs, d_de, d_ls, d_fs}, d_px, d_py);
         end
      end
      en_d = 1'b1;
      wait_tick_d(n);
      vectors++;
      if (n != 2 || {d_de, d_ls, d_fs, d_px, d_py} !== {3'b111, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL restart got lat=%0d %b_%0d_%0d want lat=2 111_0_0", n,
                  {d_de, d_ls, d_fs}, d_px, d_py);
      end
   endtask

   task automatic test_small_raster;
      int h, v, h1, v1;
      logic e_de, e1_de;
      logic [6+2*W-1:0] got, exp;
      en_s = 1'b1;
      for (int k = 0; k < 96; k++) begin
         @(negedge clk);
         h = k % 8;
         v = (k / 8) % 6;
         e_de = (h < 4) && (v < 3);
         exp = {1'b1, (h >= 5 && h <= 6), (v == 4), e_de, (h == 0), (h == 0 && v == 0),
                e_de ? W'(h) : 11'd0, e_de ? W'(v) : 11'd0};
         got = {s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs, s_px, s_py};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL small_tick_%0d got %b_%0d_%0d want %b_%0d_%0d", k,
                     got[6+2*W-1:2*W], s_px, s_py, exp[6+2*W-1:2*W], exp[2*W-1:W], exp[W-1:0]);
         end
`ifdef VGA_TIMING_PREFETCH_EN
         h1 = (k + 1) % 8;
         v1 = ((k + 1) / 8) % 6;
         e1_de = (h1 < 4) && (v1 < 3);
         vectors++;
         if ({s_fde, s_fx, s_fy} !== {e1_de, e1_de ? W'(h1) : 11'd0, e1_de ? W'(v1) : 11'd0}) begin
            miscompares++;
            $display("FAIL small_fetch_%0d got %b_%0d_%0d want %b_%0d_%0d", k, s_fde, s_fx, s_fy,
                     e1_de, h1, v1);
         end
`else
         h1 = 0; v1 = 0; e1_de = 1'b0;
`endif
      end
   endtask

   task automatic test_small_restart;
      en_s = 1'b0;
      @(negedge clk);
      vectors++;
      if ({s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs, s_px, s_py} !== {6'b000000, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL small_en_low got %b_%0d_%0d want 000000_0_0",
                  {s_pix_ce, s_hs, s_vs, s_de, s_ls, s_fs}, s_px, s_py);
      end
      en_s = 1'b1;
      @(negedge clk);
      vectors++;
      if ({s_pix_ce, s_de, s_ls, s_fs, s_px, s_py} !== {4'b1111, 11'd0, 11'd0}) begin
         miscompares++;
         $display("FAIL small_restart got %b_%0d_%0d want 1111_0_0",
                  {s_pix_ce, s_de, s_ls, s_fs}, s_px, s_py);
      end
   endtask

   initial begin
      test_reset();
      test_first_tick();
      test_line();
      test_en_drop();
      test_small_raster();
      test_small_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
